// File: rtl/ram_hs_arb.sv
// Round-robin arbiter sharing one handshake SRAM wrapper among NUM_PORT requesters.
// Writes and reads arbitrate independently. The read side tracks the single
// outstanding read so that the response is steered back to the port that issued it.
module ram_hs_arb #(
  parameter int NUM_PORT   = 4,
  parameter int SRAM_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int IDX_WIDTH  = $clog2(NUM_PORT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORT-1:0]              p_wvalid,
  output logic [NUM_PORT-1:0]              p_wready,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0]   p_waddr,
  input  logic [NUM_PORT*SRAM_WIDTH-1:0]   p_wdata,
  input  logic [NUM_PORT-1:0]              p_arvalid,
  output logic [NUM_PORT-1:0]              p_arready,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0]   p_araddr,
  output logic [NUM_PORT-1:0]              p_rvalid,
  input  logic [NUM_PORT-1:0]              p_rready,
  output logic [SRAM_WIDTH-1:0]            p_rdata,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  output logic [ADDR_WIDTH-1:0]            m_waddr,
  output logic [SRAM_WIDTH-1:0]            m_wdata,
  output logic                             m_arvalid,
  input  logic                             m_arready,
  output logic [ADDR_WIDTH-1:0]            m_araddr,
  input  logic                             m_rvalid,
  output logic                             m_rready,
  input  logic [SRAM_WIDTH-1:0]            m_rdata,
  output logic                             rd_busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   wptr;
  logic [IDX_WIDTH-1:0]   rptr;
  logic [IDX_WIDTH-1:0]   owner;
  logic [IDX_WIDTH-1:0]   wwin;
  logic [IDX_WIDTH-1:0]   awin;
  logic                   any_ar;

  // First requesting port searching upward from ptr+1, wrapping after NUM_PORT-1.
  // With no requester the result is ptr; callers gate on the OR of the requests.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_PORT-1:0] req,
                                                   input logic [IDX_WIDTH-1:0] ptr);
    logic [IDX_WIDTH-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= NUM_PORT; k++) begin
      idx = IDX_WIDTH'((int'(ptr) + k) % NUM_PORT);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Write channel: combinational grant, winner's address/data muxed straight through
  always_comb begin
    wwin     = rr_pick(p_wvalid, wptr);
    m_wvalid = |p_wvalid;
    m_waddr  = p_waddr[wwin*ADDR_WIDTH +: ADDR_WIDTH];
    m_wdata  = p_wdata[wwin*SRAM_WIDTH +: SRAM_WIDTH];
    p_wready = '0;
    if (m_wvalid) p_wready[wwin] = m_wready;
  end

  // Write priority pointer advances to the port just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= IDX_WIDTH'(NUM_PORT - 1);
    end else if (m_wvalid && m_wready) begin
      wptr <= wwin;
    end
  end

  // Read channel steering; m_rready stays high in IDLE because the memory
  // ties arready to rready, so dropping it would block every read request
  always_comb begin
    awin      = rr_pick(p_arvalid, rptr);
    any_ar    = |p_arvalid;
    m_araddr  = p_araddr[awin*ADDR_WIDTH +: ADDR_WIDTH];
    m_arvalid = 1'b0;
    m_rready  = 1'b1;
    p_arready = '0;
    p_rvalid  = '0;
    if (state == ST_IDLE) begin
      m_arvalid = any_ar;
      if (any_ar) p_arready[awin] = m_arready;
    end else begin
      p_rvalid[owner] = m_rvalid;
      m_rready        = p_rready[owner];
    end
  end

  // Read data is broadcast; only the owner's p_rvalid qualifies it
  assign p_rdata = m_rdata;

  // Read FSM: one outstanding read, owner remembered until its response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rptr    <= IDX_WIDTH'(NUM_PORT - 1);
      owner   <= '0;
      rd_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_arvalid && m_arready) begin
            owner   <= awin;
            rptr    <= awin;
            state   <= ST_WAIT;
            rd_busy <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (m_rvalid && m_rready) begin
            state   <= ST_IDLE;
            rd_busy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          rd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_hs_arb.sv
// Bench for ram_hs_arb: behavioural handshake SRAM, per-port request FIFOs,
// and write/read scoreboards holding the hand-derived grant order.
module tb_ram_hs_arb;
  localparam int NP = 4;
  localparam int SW = 128;
  localparam int AW = 6;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     p_wvalid, p_wready, p_arvalid, p_arready, p_rvalid, p_rready;
  logic [NP*AW-1:0]  p_waddr, p_araddr;
  logic [NP*SW-1:0]  p_wdata;
  logic [SW-1:0]     p_rdata;
  logic              m_wvalid, m_wready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]     m_waddr, m_araddr;
  logic [SW-1:0]     m_wdata, m_rdata;
  logic              rd_busy;

  ram_hs_arb #(.NUM_PORT(NP), .SRAM_WIDTH(SW), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_wvalid(p_wvalid), .p_wready(p_wready), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .p_arvalid(p_arvalid), .p_arready(p_arready), .p_araddr(p_araddr),
    .p_rvalid(p_rvalid), .p_rready(p_rready), .p_rdata(p_rdata),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .rd_busy(rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: arready tied to rready, data valid the cycle after acceptance
  logic [SW-1:0] mem [64];
  assign m_arready = m_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
    end else begin
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (m_wvalid && m_wready) mem[m_waddr] <= m_wdata;
  end

  typedef struct { int port; logic [AW-1:0] addr; logic [SW-1:0] data; } wexp_t;
  typedef struct { int port; logic [SW-1:0] data; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  logic [AW-1:0] wa [NP][16];
  logic [SW-1:0] wd [NP][16];
  logic [AW-1:0] ra [NP][16];
  int wn[NP], wh[NP], rn[NP], rh[NP];
  logic [NP-1:0] rr_mask;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [NP-1:0] v);
    idx_of = -1;
    for (int i = NP - 1; i >= 0; i--) if (v[i]) idx_of = i;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      p_wvalid[p]            = wh[p] < wn[p];
      p_waddr[p*AW +: AW]    = wa[p][wh[p] & 15];
      p_wdata[p*SW +: SW]    = wd[p][wh[p] & 15];
      p_arvalid[p]           = rh[p] < rn[p];
      p_araddr[p*AW +: AW]   = ra[p][rh[p] & 15];
    end
    p_rready = rr_mask;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin
      wn[p] = 0; wh[p] = 0; rn[p] = 0; rh[p] = 0;
      for (int k = 0; k < 16; k++) begin
        wa[p][k] = '0; wd[p][k] = '0; ra[p][k] = '0;
      end
    end
    wq.delete();
    rq.delete();
    rr_mask = '1;
    drive();
  endtask

  task automatic add_wr(input int p, input int a, input logic [SW-1:0] d);
    wa[p][wn[p]] = AW'(a);
    wd[p][wn[p]] = d;
    wn[p]++;
  endtask

  task automatic exp_wr(input int p, input int a, input logic [SW-1:0] d);
    wexp_t e;
    e.port = p; e.addr = AW'(a); e.data = d;
    wq.push_back(e);
  endtask

  task automatic add_rd(input int p, input int a);
    ra[p][rn[p]] = AW'(a);
    rn[p]++;
  endtask

  task automatic exp_rd(input int p, input logic [SW-1:0] d);
    rexp_t e;
    e.port = p; e.data = d;
    rq.push_back(e);
  endtask

  // One clock: monitor handshakes at the falling edge, advance FIFOs after the rising edge
  task automatic step();
    logic [NP-1:0] wf, af;
    wexp_t we;
    rexp_t re;
    int wp, rp;
    @(negedge clk);
    cyc++;
    wf = '0;
    af = p_arvalid & p_arready;
    if (m_wvalid && m_wready) begin
      wf = p_wvalid & p_wready;
      wp = idx_of(p_wready);
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        we = wq.pop_front();
        chk("wr_port", wp, we.port);
        chk("wr_addr", m_waddr, we.addr);
        chk("wr_data", m_wdata, we.data);
      end
    end
    if (p_rvalid != '0) begin
      rp = idx_of(p_rvalid);
      chk("rvalid_onehot", $onehot(p_rvalid), 1);
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        chk("rvalid_port", rp, rq[0].port);
        if (p_rready[rp]) begin
          re = rq.pop_front();
          chk("rd_data", p_rdata, re.data);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (wf[p]) wh[p]++;
      if (af[p]) rh[p]++;
    end
    drive();
  endtask

  function automatic bit pending();
    pending = (wq.size() != 0) || (rq.size() != 0) || rd_busy;
    for (int p = 0; p < NP; p++) if (wh[p] < wn[p] || rh[p] < rn[p]) pending = 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", n >= budget, 0);
  endtask

  task automatic reset_checks();
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_p_wready", p_wready, 0);
    chk("rst_p_arready", p_arready, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    #1;
    reset_checks();
    step();
    step();
    reset_checks();
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, n;
    rst_n    = 1'b0;
    m_wready = 1'b1;
    clear_all();
    do_reset();

    // All ports write continuously; port 0 also writes addr 9 last
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) add_wr(p, 4*k + p, SW'(p*16 + k));
    add_wr(0, 9, SW'('h99));
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) exp_wr(p, 4*k + p, SW'(p*16 + k));
    exp_wr(0, 9, SW'('h99));
    m_wready = 1'b0;
    drive();
    #1;
    chk("wstall_m_wvalid", m_wvalid, 1);
    chk("wstall_p_wready", p_wready, 0);
    chk("wstall_m_waddr", m_waddr, 0);
    step();
    m_wready = 1'b1;
    c0 = cyc;
    wait_idle(50);
    chk("wr_cycles", cyc - c0, 9);

    // Same-cycle reads from ports 1 and 3 straight out of reset
    do_reset();
    add_rd(1, 5); add_rd(3, 9);
    exp_rd(1, SW'(17)); exp_rd(3, SW'('h99));
    drive();
    wait_idle(50);

    // Read back addresses 0..7 from port 0, one read per two cycles
    for (int a = 0; a < 8; a++) begin
      add_rd(0, a);
      exp_rd(0, SW'((a % 4)*16 + a/4));
    end
    drive();
    c0 = cyc;
    wait_idle(100);
    chk("rd_cycles", cyc - c0, 16);

    // Port 2 read stalled on rready while port 0 writes
    rr_mask[2] = 1'b0;
    add_rd(2, 2); exp_rd(2, SW'(32));
    drive();
    n = 0;
    while (!rd_busy && n < 10) begin step(); n++; end
    chk("stall_busy_start", rd_busy, 1);
    for (int i = 0; i < 5; i++) begin
      add_wr(0, 20 + i, SW'('h100 + i));
      exp_wr(0, 20 + i, SW'('h100 + i));
    end
    drive();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_busy", rd_busy, 1);
      chk("stall_rdata", p_rdata, 32);
      chk("stall_wr_done", wh[0], i + 1);
    end
    rr_mask = '1;
    drive();
    step();
    chk("stall_delivered", rq.size(), 0);
    chk("stall_busy_end", rd_busy, 0);

    // Fairness: port 0 continuous, port 2 joins after port 0's first grant
    for (int i = 0; i < 6; i++) add_wr(0, 40 + i, SW'('h200 + i));
    add_rd(0, 0); add_rd(0, 1); add_rd(0, 2);
    exp_wr(0, 40, SW'('h200));
    exp_rd(0, SW'(0));
    drive();
    step();
    add_wr(2, 50, SW'('h2aa));
    exp_wr(2, 50, SW'('h2aa));
    for (int i = 1; i < 6; i++) exp_wr(0, 40 + i, SW'('h200 + i));
    add_rd(2, 3);
    exp_rd(2, SW'(48)); exp_rd(0, SW'(16)); exp_rd(0, SW'(32));
    drive();
    wait_idle(100);

    // Write addr 3 then read it back from another port one cycle later
    add_wr(1, 3, SW'('hA5));
    exp_wr(1, 3, SW'('hA5));
    drive();
    step();
    add_rd(3, 3);
    exp_rd(3, SW'('hA5));
    drive();
    wait_idle(50);

    // Reset while a read is outstanding; the read is dropped
    add_rd(1, 5);
    exp_rd(1, SW'(17));
    drive();
    n = 0;
    while (!rd_busy && n < 10) begin step(); n++; end
    chk("midrst_busy", rd_busy, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rvalid", p_rvalid, 0);
      chk("post_rst_busy", rd_busy, 0);
    end
    add_rd(0, 9);
    exp_rd(0, SW'('h99));
    drive();
    wait_idle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_hs_arb.md
# ram_hs_arb

Round-robin arbiter that shares one handshake single-port-pair SRAM wrapper (independent write channel and read-address/read-data channels, read data valid the cycle after acceptance) among NUM_PORT requesters. Sits between compute/DMA engines and the on-chip buffer. It runs write and read arbitration independently and tracks the single outstanding read so the response is routed back to its owner.

## Interface
- NUM_PORT, 4, number of requesters (≥2)
- SRAM_WIDTH, 128, data width in bits
- ADDR_WIDTH, 6, word address width
- IDX_WIDTH, $clog2(NUM_PORT), port index width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- p_wvalid  in  NUM_PORT  per-port write request
- p_wready  out  NUM_PORT  per-port write accept
- p_waddr  in  NUM_PORT*ADDR_WIDTH  write addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- p_wdata  in  NUM_PORT*SRAM_WIDTH  write data, same packing
- p_arvalid  in  NUM_PORT  per-port read request
- p_arready  out  NUM_PORT  per-port read accept
- p_araddr  in  NUM_PORT*ADDR_WIDTH  read addresses
- p_rvalid  out  NUM_PORT  per-port read data valid
- p_rready  in  NUM_PORT  per-port read data accept
- p_rdata  out  SRAM_WIDTH  read data, broadcast to all ports; qualify with p_rvalid
- m_wvalid/m_wready/m_waddr/m_wdata  out/in/out/out  1/1/ADDR_WIDTH/SRAM_WIDTH  memory write channel
- m_arvalid/m_arready/m_araddr  out/in/out  1/1/ADDR_WIDTH  memory read-address channel
- m_rvalid/m_rready/m_rdata  in/out/in  1/1/SRAM_WIDTH  memory read-data channel
- rd_busy  out  1  high while a read is outstanding

## Operation
- Write path, combinational grant: starting at wptr+1 (mod NUM_PORT), first port with p_wvalid wins. m_wvalid = |p_wvalid. Winner's address and data are muxed to m_waddr/m_wdata. p_wready[winner] = m_wready; all other p_wready = 0.
- wptr <= winner on m_wvalid & m_wready. The grant is stable while unaccepted because requesters hold valid.
- Read FSM, 2 states:
  - IDLE: grant computed from rptr as above over p_arvalid. m_arvalid = |p_arvalid; m_araddr = winner's address; m_rready = 1. p_arready[winner] = m_arready; others 0. On m_arvalid & m_arready: owner <= winner, rptr <= winner, go to WAIT.
  - WAIT: m_arvalid = 0; all p_arready = 0. p_rvalid[owner] = m_rvalid; others 0. m_rready = p_rready[owner]. On m_rvalid & m_rready, go to IDLE.
- m_rready = 1 in IDLE is required: the memory ties arready to rready, so m_rready = 0 in IDLE would deadlock reads.
- p_rdata = m_rdata unconditionally.
- Read and write paths never block each other. Same-cycle read and write to the same address resolve with the memory's native ordering; the arbiter adds no forwarding.
- rd_busy = (state == WAIT).

## Timing
- Reset values: state IDLE, wptr = rptr = NUM_PORT-1 (port 0 has first priority), owner = 0, rd_busy = 0, all p_rvalid = 0, m_arvalid = m_wvalid = 0 when no request.
- Write: 0 added latency. Accepted in the same cycle as the request when m_wready = 1. One write per cycle sustained.
- Read: accepted in cycle N (IDLE). m_rvalid is seen from N+1; p_rvalid[owner] follows combinationally. Next read can be accepted no earlier than the cycle after the response handshake, so sustained throughput is 1 read per 2 cycles.
- Owner stalls with p_rready = 0: FSM stays in WAIT and m_rvalid/m_rdata hold. Other ports' read requests wait. Writes are unaffected.
- Fairness: a continuously requesting port waits at most NUM_PORT-1 grants per channel.
- Pointer wrap: port NUM_PORT-1 is followed by port 0.
- Reset mid-read: FSM returns to IDLE and the outstanding read is dropped. Memory shares rst_n, so m_rvalid also clears. No p_rvalid pulse after reset release.

## Test plan
- All 4 ports write continuously, m_wready = 1 -> grants in order 0,1,2,3,0,… one per cycle; memory contents match addresses 0..7 written with data = port*16+k.
- Ports 1 and 3 read addrs 5 and 9 in the same cycle from reset -> port 1 is served first (p_rvalid[1] with mem[5]), then port 3 gets mem[9]; p_rvalid[3] is never high while owner = 1.
- Port 2 read with p_rready[2] = 0 for 5 cycles while port 0 issues writes -> writes complete each cycle, rd_busy stays 1, p_rdata is stable, and data is delivered on the first rready cycle.
- Port 0 requests continuously while port 2 requests once -> port 2 is granted within 1 grant on both the read and write channels.
- Write addr 3 = 0xA5 in cycle N, then read addr 3 from another port at N+1 -> returns 0xA5.
- Assert rst_n low in WAIT, release after 2 cycles -> rd_busy = 0, no p_rvalid, and a new read from port 0 completes normally.
